decoded_bit_reorder: RTL and testbench



---
 rtl/decoded_bit_reorder.sv | 138 +++++++++++++
 tb/tb_decoded_bit_reorder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decoded_bit_reorder.sv
// Ping-pong LIFO that restores forward bit order behind the traceback stage.
// Drops the first WARMUP_BLOCKS complete blocks and flags short/long blocks (sticky).
module decoded_bit_reorder #(
  parameter int BLOCK_LEN     = 21,
  parameter int WARMUP_BLOCKS = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic reverse_decoded_bit_in,
  input  logic stack_toggle_in,
  output logic decoded_bit_out,
  output logic decoded_valid_out,
  output logic block_start_out,
  output logic frame_err_out
);

  localparam int PW = $clog2(BLOCK_LEN + 1);
  localparam int RW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam int CW = $clog2(WARMUP_BLOCKS + 1);

  typedef enum logic {IDLE, PLAY} state_t;

  logic [BLOCK_LEN-1:0] bank_a, bank_b;
  logic                 wr_bank;
  logic                 toggle_d;
  logic                 seen_bnd;
  logic                 ovf;
  logic [PW-1:0]        wptr;
  logic [RW-1:0]        rptr, rptr_nxt;
  logic [CW-1:0]        warm_cnt;
  state_t               state, state_nxt;

  logic          boundary, full, complete, short_blk, overflow, warmed, replay;
  logic          wr_en, wr_sel;
  logic [RW-1:0] widx;
  logic          closing_msb, rd_bit;
  logic          bit_nxt, vld_nxt, start_nxt;

  assign boundary  = (stack_toggle_in != toggle_d);
  assign full      = (wptr == PW'(BLOCK_LEN));
  // An overflowed block also ends with wptr at BLOCK_LEN, so ovf disqualifies it.
  assign complete  = boundary && full && !ovf;
  assign short_blk = boundary && !full && seen_bnd;
  assign overflow  = !boundary && full;
  assign warmed    = (warm_cnt == CW'(WARMUP_BLOCKS));
  assign replay    = complete && warmed;

  // The bank being closed is still wr_bank during the boundary cycle.
  assign closing_msb = wr_bank ? bank_b[BLOCK_LEN-1] : bank_a[BLOCK_LEN-1];
  assign rd_bit      = wr_bank ? bank_a[rptr] : bank_b[rptr];

  always_comb begin
    wr_en  = 1'b1;
    wr_sel = wr_bank;
    widx   = wptr[RW-1:0];
    if (boundary) begin
      wr_sel = ~wr_bank;
      widx   = '0;
    end else if (full) begin
      wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_sel) bank_b[widx] <= reverse_decoded_bit_in;
      else        bank_a[widx] <= reverse_decoded_bit_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      toggle_d      <= 1'b0;
      wr_bank       <= 1'b0;
      wptr          <= '0;
      seen_bnd      <= 1'b0;
      ovf           <= 1'b0;
      warm_cnt      <= '0;
      frame_err_out <= 1'b0;
    end else begin
      toggle_d <= stack_toggle_in;
      if (boundary) begin
        wr_bank  <= ~wr_bank;
        wptr     <= PW'(1);
        seen_bnd <= 1'b1;
        ovf      <= 1'b0;
        if (complete && !warmed) warm_cnt <= warm_cnt + CW'(1);
      end else if (full) begin
        ovf <= 1'b1;
      end else begin
        wptr <= wptr + PW'(1);
      end
      if (short_blk || overflow) frame_err_out <= 1'b1;
    end
  end

  // The MSB is read on the boundary cycle itself, so PLAY continues from BLOCK_LEN-2.
  always_comb begin
    state_nxt = state;
    rptr_nxt  = rptr;
    bit_nxt   = 1'b0;
    vld_nxt   = 1'b0;
    start_nxt = 1'b0;
    if (boundary) begin
      if (replay) begin
        state_nxt = PLAY;
        rptr_nxt  = RW'(BLOCK_LEN - 2);
        bit_nxt   = closing_msb;
        vld_nxt   = 1'b1;
        start_nxt = 1'b1;
      end else begin
        state_nxt = IDLE;
      end
    end else if (state == PLAY) begin
      bit_nxt  = rd_bit;
      vld_nxt  = 1'b1;
      rptr_nxt = rptr - RW'(1);
      if (rptr == '0) state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      rptr              <= '0;
      decoded_bit_out   <= 1'b0;
      decoded_valid_out <= 1'b0;
      block_start_out   <= 1'b0;
    end else begin
      state             <= state_nxt;
      rptr              <= rptr_nxt;
      decoded_bit_out   <= bit_nxt;
      decoded_valid_out <= vld_nxt;
      block_start_out   <= start_nxt;
    end
  end

endmodule

// File: tb/tb_decoded_bit_reorder.sv
// Directed bench for decoded_bit_reorder: warm-up, ordering, framing errors, reset.
module tb_decoded_bit_reorder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic din = 1'b0;
  logic tog = 1'b0;
  logic dout, dvld, dstart, derr;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int err_edge = -1;
  logic lg_bit[$];
  logic lg_start[$];
  int   lg_edge[$];
  int   bnd[$];

  decoded_bit_reorder #(.BLOCK_LEN(21), .WARMUP_BLOCKS(3)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .reverse_decoded_bit_in (din),
    .stack_toggle_in        (tog),
    .decoded_bit_out        (dout),
    .decoded_valid_out      (dvld),
    .block_start_out        (dstart),
    .frame_err_out          (derr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Output log, sampled mid-cycle; edge_n tags which cycle each bit was visible in.
  always @(negedge clk) begin
    if (!reset_n) begin
      lg_bit.delete();
      lg_start.delete();
      lg_edge.delete();
      err_edge = -1;
    end else begin
      if (dvld === 1'b1) begin
        lg_bit.push_back(dout);
        lg_start.push_back(dstart);
        lg_edge.push_back(edge_n);
      end
      if (derr === 1'b1 && err_edge < 0) err_edge = edge_n;
    end
  end

  function automatic logic [20:0] pat_k(input int k);
    return 21'h0A5A5A ^ 21'(k);
  endfunction

  function automatic logic [20:0] word_at(input int base);
    logic [20:0] w;
    w = '0;
    for (int j = 0; j < 21; j++) w[j] = lg_bit[base + j];
    return w;
  endfunction

  // Bits go in MSB first; the first bit carries the toggle flip.
  task automatic feed_block(input logic [20:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i < 21) din = p[20 - i];
      else        din = 1'b1;
      if (i == 0) begin
        tog = ~tog;
        bnd.push_back(edge_n + 1);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    tog = 1'b0;
    din = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bnd.delete();
  endtask

  task automatic warmup();
    for (int k = 0; k < 3; k++) feed_block(pat_k(k), 21);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (dout !== 1'b0)   begin errors++; $display("FAIL reset_bit: got %b want 0", dout); end
    checks++; if (dvld !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b want 0", dvld); end
    checks++; if (dstart !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", dstart); end
    checks++; if (derr !== 1'b0)   begin errors++; $display("FAIL reset_err: got %b want 0", derr); end
    reset_n = 1'b1;
    idle(2);
    checks++; if (dvld !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", dvld); end
    checks++; if (derr !== 1'b0) begin errors++; $display("FAIL post_reset_err: got %b want 0", derr); end
  endtask

  task automatic test_steady();
    int bad;
    do_reset();
    for (int k = 0; k < 7; k++) feed_block(pat_k(k), 21);
    feed_block(21'h0, 1);
    idle(2);
    checks++;
    if (lg_bit.size() < 63) begin
      errors++; $display("FAIL steady_count: got %0d valid bits want >= 63", lg_bit.size());
    end else begin
      checks++;
      if (lg_edge[0] !== bnd[4]) begin
        errors++; $display("FAIL steady_latency: first valid at edge %0d want %0d", lg_edge[0], bnd[4]);
      end
      for (int b = 0; b < 3; b++) begin
        checks++;
        if (word_at(21 * b) !== pat_k(3 + b)) begin
          errors++; $display("FAIL steady_block%0d: got %h want %h", 3 + b, word_at(21 * b), pat_k(3 + b));
        end
      end
      bad = 0;
      for (int j = 1; j < 63; j++) if (lg_edge[j] != lg_edge[0] + j) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL steady_gapless: %0d gaps want 0", bad); end
      bad = 0;
      for (int j = 0; j < 63; j++) if (lg_start[j] !== ((j % 21) == 0)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL steady_start: %0d wrong flags want 0", bad); end
    end
    checks++; if (derr !== 1'b0) begin errors++; $display("FAIL steady_err: got %b want 0", derr); end
  endtask

  task automatic test_ordering();
    do_reset();
    warmup();
    feed_block(21'h100000, 21);
    feed_block(21'h0, 21);
    idle(1);
    checks++;
    if (lg_bit.size() != 21) begin
      errors++; $display("FAIL order_count: got %0d valid bits want 21", lg_bit.size());
    end else begin
      checks++;
      if (word_at(0) !== 21'h100000) begin
        errors++; $display("FAIL order_word: got %h want 100000", word_at(0));
      end
    end
  endtask

  task automatic test_short();
    do_reset();
    warmup();
    feed_block(pat_k(7), 15);
    feed_block(pat_k(8), 21);
    feed_block(21'h0, 21);
    idle(1);
    checks++; if (err_edge != bnd[4]) begin errors++; $display("FAIL short_err_time: edge %0d want %0d", err_edge, bnd[4]); end
    checks++;
    if (lg_bit.size() != 21) begin
      errors++; $display("FAIL short_count: got %0d valid bits want 21", lg_bit.size());
    end else begin
      checks++; if (lg_edge[0] != bnd[5]) begin errors++; $display("FAIL short_next_time: edge %0d want %0d", lg_edge[0], bnd[5]); end
      checks++; if (word_at(0) !== pat_k(8)) begin errors++; $display("FAIL short_next_word: got %h want %h", word_at(0), pat_k(8)); end
    end
  endtask

  task automatic test_long();
    do_reset();
    warmup();
    feed_block(pat_k(9), 25);
    feed_block(pat_k(10), 21);
    feed_block(21'h0, 21);
    idle(1);
    checks++; if (err_edge != bnd[3] + 21) begin errors++; $display("FAIL long_err_time: edge %0d want %0d", err_edge, bnd[3] + 21); end
    checks++;
    if (lg_bit.size() != 21) begin
      errors++; $display("FAIL long_count: got %0d valid bits want 21", lg_bit.size());
    end else begin
      checks++; if (lg_edge[0] != bnd[5]) begin errors++; $display("FAIL long_next_time: edge %0d want %0d", lg_edge[0], bnd[5]); end
      checks++; if (word_at(0) !== pat_k(10)) begin errors++; $display("FAIL long_next_word: got %h want %h", word_at(0), pat_k(10)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [20:0] p4;
    p4 = pat_k(4);
    do_reset();
    for (int k = 0; k < 5; k++) feed_block(pat_k(k), 21);
    feed_block(pat_k(5), 11);
    @(posedge clk);
    #2;
    checks++; if (dvld !== 1'b1)  begin errors++; $display("FAIL mid_valid: got %b want 1", dvld); end
    checks++; if (dout !== p4[10]) begin errors++; $display("FAIL mid_bit10: got %b want %b", dout, p4[10]); end
    reset_n = 1'b0;
    tog = 1'b0;
    din = 1'b0;
    #1;
    checks++;
    if ({dout, dvld, dstart, derr} !== 4'b0000) begin
      errors++; $display("FAIL mid_async_clear: got %b want 0000", {dout, dvld, dstart, derr});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bnd.delete();
    warmup();
    feed_block(pat_k(3), 21);
    feed_block(21'h0, 21);
    idle(1);
    checks++;
    if (lg_bit.size() != 21) begin
      errors++; $display("FAIL mid_rewarm_count: got %0d valid bits want 21", lg_bit.size());
    end else begin
      checks++; if (lg_edge[0] != bnd[4]) begin errors++; $display("FAIL mid_rewarm_time: edge %0d want %0d", lg_edge[0], bnd[4]); end
      checks++; if (word_at(0) !== pat_k(3)) begin errors++; $display("FAIL mid_rewarm_word: got %h want %h", word_at(0), pat_k(3)); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    warmup();
    feed_block(pat_k(11), 1);
    feed_block(pat_k(12), 21);
    feed_block(21'h0, 21);
    idle(1);
    checks++; if (err_edge != bnd[4]) begin errors++; $display("FAIL b2b_err_time: edge %0d want %0d", err_edge, bnd[4]); end
    checks++;
    if (lg_bit.size() != 21) begin
      errors++; $display("FAIL b2b_count: got %0d valid bits want 21", lg_bit.size());
    end else begin
      checks++; if (lg_edge[0] != bnd[5]) begin errors++; $display("FAIL b2b_recover_time: edge %0d want %0d", lg_edge[0], bnd[5]); end
      checks++; if (word_at(0) !== pat_k(12)) begin errors++; $display("FAIL b2b_recover_word: got %h want %h", word_at(0), pat_k(12)); end
      checks++; if (lg_start[0] !== 1'b1) begin errors++; $display("FAIL b2b_start: got %b want 1", lg_start[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_ordering();
    test_short();
    test_long();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
